// File: rtl/kyber_pkg.sv
// Shared constants and FSM state type for the Kyber key-generation datapath.
package kyber_pkg;
   localparam int K_DEF  = 2;
   localparam int N_DEF  = 4;
   localparam int Q_DEF  = 17;
   localparam int CW_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MAC,
      ST_DONE
   } state_t;
endpackage

// File: rtl/mod_q_reduce.sv
// Combinational map of a signed W-bit value into [0, Q-1]; zero latency, no flow control.
module mod_q_reduce
   import kyber_pkg::*;
#(
   parameter int W  = CW_DEF,
   parameter int Q  = Q_DEF,
   parameter int OW = $clog2(Q_DEF)
) (
   input  logic signed [W-1:0]  x_i,
   output logic        [OW-1:0] r_o
);
   localparam logic signed [W:0] QS = (W+1)'(Q);

   logic signed [W:0] rem_s;

   // Truncating % leaves a remainder in (-Q, Q); fold negatives back up.
   always_comb begin
      rem_s = $signed({x_i[W-1], x_i}) % QS;
      if (rem_s[W]) rem_s = rem_s + QS;
   end

   assign r_o = OW'(rem_s);
endmodule

// File: rtl/kyber_keygen_seq.sv
// t = A*s + e over Z_Q[x]/(x^N+1), one coefficient product per cycle; done K*K*N*N+2 cycles
// after start is accepted. No backpressure: start outside IDLE is dropped, results hold until next done.
module kyber_keygen_seq
   import kyber_pkg::*;
#(
   parameter int K  = K_DEF,
   parameter int N  = N_DEF,
   parameter int Q  = Q_DEF,
   parameter int CW = CW_DEF
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      start,
   input  logic signed [K-1:0][K-1:0][N-1:0][CW-1:0] a_in,
   input  logic signed [K-1:0][N-1:0][CW-1:0]        s_in,
   input  logic signed [K-1:0][N-1:0][CW-1:0]        e_in,
   output logic                                      busy,
   output logic                                      done,
   output logic [K-1:0][N-1:0][CW-1:0]               t_out,
   output logic [K-1:0][N-1:0][CW-1:0]               sk_out
);
   localparam int QW = $clog2(Q);
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam int NW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] KMAX = KW'(K - 1);
   localparam logic [NW-1:0] NMAX = NW'(N - 1);
   localparam logic [NW:0]   NL   = (NW+1)'(N);
   localparam logic [QW:0]   QL   = (QW+1)'(Q);

   state_t                             state_q;
   logic [K-1:0][K-1:0][N-1:0][CW-1:0] a_raw_q;
   logic [K-1:0][N-1:0][CW-1:0]        s_raw_q, e_raw_q;
   logic [K-1:0][K-1:0][N-1:0][QW-1:0] a_r_q, a_red;
   logic [K-1:0][N-1:0][QW-1:0]        s_r_q, s_red, e_red, acc_q;
   logic [KW-1:0]                      i_q, j_q;
   logic [NW-1:0]                      m_q, n_q;
   logic                               busy_q, done_q;
   logic [K-1:0][N-1:0][CW-1:0]        t_q, sk_q;

   for (genvar gi = 0; gi < K; gi++) begin : g_red_row
      for (genvar gm = 0; gm < N; gm++) begin : g_red_coef
         mod_q_reduce #(.W(CW), .Q(Q), .OW(QW)) u_s (.x_i(s_raw_q[gi][gm]), .r_o(s_red[gi][gm]));
         mod_q_reduce #(.W(CW), .Q(Q), .OW(QW)) u_e (.x_i(e_raw_q[gi][gm]), .r_o(e_red[gi][gm]));
         for (genvar gj = 0; gj < K; gj++) begin : g_red_a
            mod_q_reduce #(.W(CW), .Q(Q), .OW(QW)) u_a (.x_i(a_raw_q[gi][gj][gm]), .r_o(a_red[gi][gj][gm]));
         end
      end
   end

   logic [QW-1:0]   a_sel, s_sel, p_red, acc_cur, acc_nxt;
   logic [2*QW-1:0] prod;
   logic [NW:0]     idx;
   logic            wrap, last;
   logic [NW-1:0]   tgt;
   logic [QW:0]     sum_w;

   mod_q_reduce #(.W(2*QW+1), .Q(Q), .OW(QW)) u_prod (.x_i({1'b0, prod}), .r_o(p_red));

   // x^N = -1: products landing at degree >= N fold back with a minus sign.
   always_comb begin
      a_sel   = a_r_q[i_q][j_q][m_q];
      s_sel   = s_r_q[j_q][n_q];
      prod    = {{QW{1'b0}}, a_sel} * {{QW{1'b0}}, s_sel};
      idx     = {1'b0, m_q} + {1'b0, n_q};
      wrap    = (idx >= NL);
      tgt     = wrap ? NW'(idx - NL) : NW'(idx);
      acc_cur = acc_q[i_q][tgt];
      sum_w   = '0;
      if (!wrap) begin
         sum_w = {1'b0, acc_cur} + {1'b0, p_red};
         if (sum_w >= QL) sum_w = sum_w - QL;
      end else if (acc_cur >= p_red) begin
         sum_w = {1'b0, acc_cur} - {1'b0, p_red};
      end else begin
         sum_w = {1'b0, acc_cur} + QL - {1'b0, p_red};
      end
      acc_nxt = QW'(sum_w);
      last    = (i_q == KMAX) && (j_q == KMAX) && (m_q == NMAX) && (n_q == NMAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_raw_q <= '0;
         s_raw_q <= '0;
         e_raw_q <= '0;
         a_r_q   <= '0;
         s_r_q   <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         m_q     <= '0;
         n_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         t_q     <= '0;
         sk_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_raw_q <= a_in;
                  s_raw_q <= s_in;
                  e_raw_q <= e_in;
                  busy_q  <= 1'b1;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               a_r_q   <= a_red;
               s_r_q   <= s_red;
               acc_q   <= e_red;
               i_q     <= '0;
               j_q     <= '0;
               m_q     <= '0;
               n_q     <= '0;
               state_q <= ST_MAC;
            end
            ST_MAC: begin
               acc_q[i_q][tgt] <= acc_nxt;
               if (n_q == NMAX) begin
                  n_q <= '0;
                  if (m_q == NMAX) begin
                     m_q <= '0;
                     if (j_q == KMAX) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                     end else begin
                        j_q <= j_q + 1'b1;
                     end
                  end else begin
                     m_q <= m_q + 1'b1;
                  end
               end else begin
                  n_q <= n_q + 1'b1;
               end
               if (last) state_q <= ST_DONE;
            end
            ST_DONE: begin
               for (int x = 0; x < K; x++) begin
                  for (int c = 0; c < N; c++) begin
                     t_q[x][c]  <= {{(CW-QW){1'b0}}, acc_q[x][c]};
                     sk_q[x][c] <= {{(CW-QW){1'b0}}, s_r_q[x][c]};
                  end
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign t_out  = t_q;
   assign sk_out = sk_q;
endmodule

// File: tb/tb_kyber_keygen_seq.sv
// Randomized and directed bench for kyber_keygen_seq against a polynomial-arithmetic reference model.
module tb_kyber_keygen_seq;
   localparam int K   = 2;
   localparam int N   = 4;
   localparam int Q   = 17;
   localparam int CW  = 32;
   localparam int LAT = K*K*N*N + 2;
   localparam int VW  = K*N*CW;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic [K-1:0][K-1:0][N-1:0][CW-1:0] a_in;
   logic [K-1:0][N-1:0][CW-1:0]        s_in, e_in;
   logic                               busy, done;
   logic [K-1:0][N-1:0][CW-1:0]        t_out, sk_out;

   kyber_keygen_seq #(.K(K), .N(N), .Q(Q), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_in(a_in), .s_in(s_in), .e_in(e_in),
      .busy(busy), .done(done), .t_out(t_out), .sk_out(sk_out)
   );

   always #5 clk = ~clk;

   int a[K][K][N];
   int s[K][N];
   int e[K][N];

   always_comb begin
      a_in = '0;
      s_in = '0;
      e_in = '0;
      for (int i = 0; i < K; i++) begin
         for (int c = 0; c < N; c++) begin
            s_in[i][c] = s[i][c];
            e_in[i][c] = e[i][c];
            for (int j = 0; j < K; j++) a_in[i][j][c] = a[i][j][c];
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic longint md(input longint x);
      return ((x % Q) + Q) % Q;
   endfunction

   // Reference: plain polynomial product, then fold degree k+N onto k with x^N = -1.
   logic [K-1:0][N-1:0][CW-1:0] job_t, job_sk;
   task automatic compute_job();
      longint c[2*N];
      for (int i = 0; i < K; i++) begin
         for (int k = 0; k < 2*N; k++) c[k] = 0;
         for (int j = 0; j < K; j++)
            for (int m = 0; m < N; m++)
               for (int n = 0; n < N; n++)
                  c[m+n] += md(longint'(a[i][j][m])) * md(longint'(s[j][n]));
         for (int k = 0; k < N; k++) begin
            job_t[i][k]  = CW'(md(c[k] - c[k+N] + longint'(e[i][k])));
            job_sk[i][k] = CW'(md(longint'(s[i][k])));
         end
      end
   endtask

   // Cycle-level expectation: one job at a time, start ignored while a job is outstanding.
   int  cyc = 0;
   int  acc_e = 0;
   bit  active = 0;
   bit  exp_done = 0;
   bit  acc_now;
   logic [K-1:0][N-1:0][CW-1:0] exp_t = '0, exp_sk = '0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            active   = 0;
            exp_done = 0;
            exp_t    = '0;
            exp_sk   = '0;
         end else begin
            acc_now  = !active && start;
            exp_done = 0;
            if (active && cyc == acc_e + LAT) begin
               active   = 0;
               exp_done = 1;
               exp_t    = job_t;
               exp_sk   = job_sk;
            end
            if (acc_now) begin
               active = 1;
               acc_e  = cyc;
               compute_job();
            end
         end
         chk("busy", VW'(busy), VW'(active));
         chk("done", VW'(done), VW'(exp_done));
         chk("t_out", t_out, exp_t);
         chk("sk_out", sk_out, exp_sk);
      end
   end

   int lt[K][N];
   int lsk[K][N];

   task automatic chk_lit(input string nm);
      logic [K-1:0][N-1:0][CW-1:0] pt, ps;
      for (int i = 0; i < K; i++)
         for (int c = 0; c < N; c++) begin
            pt[i][c] = lt[i][c];
            ps[i][c] = lsk[i][c];
         end
      chk({nm, "_t"}, t_out, pt);
      chk({nm, "_sk"}, sk_out, ps);
   endtask

   task automatic clear_ops();
      for (int i = 0; i < K; i++)
         for (int c = 0; c < N; c++) begin
            s[i][c] = 0;
            e[i][c] = 0;
            for (int j = 0; j < K; j++) a[i][j][c] = 0;
         end
   endtask

   function automatic int rnd(input bit full);
      if (full) return int'($urandom);
      return int'($urandom_range(80)) - 40;
   endfunction

   task automatic rand_ops(input bit full);
      for (int i = 0; i < K; i++)
         for (int c = 0; c < N; c++) begin
            s[i][c] = rnd(full);
            e[i][c] = rnd(full);
            for (int j = 0; j < K; j++) a[i][j][c] = rnd(full);
         end
   endtask

   // Pulse start, wait (bounded) for done, check latency from the accepting edge.
   task automatic run_job(input string nm);
      int lat;
      bit got;
      @(negedge clk);
      start = 1;
      @(posedge clk);
      #2 start = 0;
      lat = 0;
      got = 0;
      while (!got && lat < 200) begin
         @(posedge clk);
         #2;
         lat++;
         if (done) got = 1;
      end
      chk({nm, "_latency"}, VW'(lat), VW'(LAT));
   endtask

   initial begin
      int ndone;
      int first_lat;
      rst_n = 0;
      start = 0;
      clear_ops();
      repeat (3) @(posedge clk);
      #2;
      chk("reset_busy", VW'(busy), '0);
      chk("reset_done", VW'(done), '0);
      chk("reset_t", t_out, '0);
      chk("reset_sk", sk_out, '0);
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(posedge clk);

      // A = 0: t is just e reduced.
      clear_ops();
      rand_ops(0);
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            for (int c = 0; c < N; c++) a[i][j][c] = 0;
      for (int c = 0; c < N; c++) begin
         e[0][c] = c + 1;
         e[1][c] = c + 5;
      end
      run_job("zero_a");
      lt = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}};
      chk("zero_a_t", t_out, {CW'(8), CW'(7), CW'(6), CW'(5), CW'(4), CW'(3), CW'(2), CW'(1)});

      // Identity matrix.
      clear_ops();
      a[0][0][0] = 1;
      a[1][1][0] = 1;
      s[0] = '{5, 6, 7, 8};
      s[1] = '{9, 10, 11, 12};
      run_job("identity");
      lt  = '{'{5, 6, 7, 8}, '{9, 10, 11, 12}};
      lsk = '{'{5, 6, 7, 8}, '{9, 10, 11, 12}};
      chk_lit("identity");

      // Multiply by x: top coefficient wraps negated.
      clear_ops();
      a[0][0] = '{0, 1, 0, 0};
      s[0]    = '{1, 2, 3, 4};
      run_job("wrap");
      lt  = '{'{13, 1, 2, 3}, '{0, 0, 0, 0}};
      lsk = '{'{1, 2, 3, 4}, '{0, 0, 0, 0}};
      chk_lit("wrap");

      // Negative and out-of-range inputs.
      clear_ops();
      e[0] = '{-1, -17, 18, -35};
      s[0] = '{-2, 0, 0, 0};
      run_job("neg");
      lt  = '{'{16, 0, 1, 16}, '{0, 0, 0, 0}};
      lsk = '{'{15, 0, 0, 0}, '{0, 0, 0, 0}};
      chk_lit("neg");

      // Randomized jobs, small and full-range coefficients.
      for (int r = 0; r < 8; r++) begin
         rand_ops(r[0]);
         run_job("random");
      end

      // Second start mid-job is dropped; inputs changed after capture are ignored.
      rand_ops(0);
      @(negedge clk);
      start = 1;
      @(posedge clk);
      #2 start = 0;
      ndone = 0;
      first_lat = 0;
      for (int c = 1; c <= 150; c++) begin
         @(posedge clk);
         #2;
         if (c == 5) rand_ops(1);
         if (c == 10) start = 1;
         if (c == 11) start = 0;
         if (done) begin
            ndone++;
            if (first_lat == 0) first_lat = c;
         end
      end
      chk("restart_dones", VW'(ndone), VW'(1));
      chk("restart_latency", VW'(first_lat), VW'(LAT));

      // start held high: back-to-back jobs, each begun right after the previous done.
      @(negedge clk);
      start = 1;
      ndone = 0;
      repeat (3 * (LAT + 1)) begin
         rand_ops(0);
         @(posedge clk);
         #2;
         if (done) ndone++;
      end
      start = 0;
      chk("held_start_dones", VW'(ndone), VW'(3));
      repeat (LAT + 5) @(posedge clk);

      // Reset mid-job abandons it.
      rand_ops(0);
      @(negedge clk);
      start = 1;
      @(posedge clk);
      #2 start = 0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst_n = 0;
      #1;
      chk("midreset_busy", VW'(busy), '0);
      chk("midreset_done", VW'(done), '0);
      chk("midreset_t", t_out, '0);
      chk("midreset_sk", sk_out, '0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      ndone = 0;
      repeat (100) begin
         @(posedge clk);
         #2;
         if (done) ndone++;
      end
      chk("midreset_no_done", VW'(ndone), '0);

      // Job after reset still works.
      rand_ops(1);
      run_job("post_reset");
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
